// File: rtl/uart_tx_core.sv
// Transmit-only UART serializer: start bit, DW data bits LSB first, stop bit.
// The tx and tx_busy outputs are registered from next-state values, so they change on the accepting edge.
module uart_tx_core #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DW        = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tx_start,
    input  logic [DW-1:0] tx_data,
    output logic          tx_busy,
    output logic          tx
);
    localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam int IDX_W = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DW - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [DW-1:0]    shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
    logic             baud_done;

    assign baud_done = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = baud_done ? '0 : cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (tx_start) begin
                    shift_next = tx_data;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    // The holding register shifts so the current bit is always at position 0.
                    shift_next = shift_reg >> 1;
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at default parameters: reset, frame decode,
// back-to-back frames, busy rejection and data stability after acceptance.
module tb_uart_tx_core;
    localparam int BP    = 868;
    localparam int FRAME = 10 * BP;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       tx;

    int checks = 0;
    int errors = 0;

    uart_tx_core dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame and decodes it at mid-bit. poke_cycle > 0 pulses tx_start with
    // poke_data that many edges after acceptance; scramble randomises tx_data every cycle.
    task automatic run_frame(input string name, input logic [7:0] data,
                             input int poke_cycle, input logic [7:0] poke_data,
                             input bit scramble);
        bit busy_drop = 0;
        bit stop_low  = 0;
        int idx;
        logic exp_bit;
        tx_data  = data;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check({name, "_accept_tx"}, tx, 0);
        check({name, "_accept_busy"}, tx_busy, 1);
        for (int c = 1; c <= FRAME; c++) begin
            tx_start = (c == poke_cycle);
            if (c == poke_cycle) tx_data = poke_data;
            else if (scramble) tx_data = 8'($urandom);
            tick();
            if (c < FRAME) begin
                if (tx_busy !== 1'b1) busy_drop = 1;
                if (c >= 9 * BP && tx !== 1'b1) stop_low = 1;
                if ((c % BP) == BP / 2) begin
                    idx = c / BP;
                    if (idx == 0) exp_bit = 1'b0;
                    else if (idx <= 8) exp_bit = data[idx-1];
                    else exp_bit = 1'b1;
                    check($sformatf("%s_bit%0d", name, idx), tx, exp_bit);
                end
            end else begin
                check({name, "_end_busy"}, tx_busy, 0);
                check({name, "_end_tx"}, tx, 1);
            end
        end
        tx_start = 1'b0;
        check({name, "_busy_held"}, busy_drop, 0);
        check({name, "_stop_high"}, stop_low, 0);
    endtask

    task automatic check_idle(input string name, input int cycles);
        bit bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (tx_busy !== 1'b0 || tx !== 1'b1) bad = 1;
        end
        check({name, "_idle"}, bad, 0);
    endtask

    task automatic reset_pulse(input string name);
        rst_i    = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'h81;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("%s_rst%0d_tx", name, i), tx, 1);
            check($sformatf("%s_rst%0d_busy", name, i), tx_busy, 0);
        end
        rst_i    = 1'b0;
        tx_start = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset_pulse("idle");
        check_idle("post_rst_idle", 20);

        // Abort mid-frame during a data bit; the frame must not resume.
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("midrst_accept_busy", tx_busy, 1);
        repeat (1500) tick();
        check("midrst_before_busy", tx_busy, 1);
        reset_pulse("mid");
        check_idle("post_midrst", 2 * BP);

        run_frame("aa", 8'b10101010, 0, 8'h00, 0);
        run_frame("f0", 8'hF0, 0, 8'h00, 0);
        run_frame("0f", 8'h0F, 0, 8'h00, 0);
        // tx_start on the final stop-bit edge must be ignored.
        run_frame("ff", 8'hFF, FRAME, 8'h77, 0);
        check_idle("ff_after", 20);
        run_frame("00", 8'h00, 0, 8'h00, 0);
        run_frame("a5", 8'hA5, FRAME / 2, 8'h55, 0);
        check_idle("a5_after", 2 * BP);
        run_frame("stab", 8'h5A, 0, 8'h00, 1);
        check_idle("stab_after", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
